// File: rtl/alu_issue_stage_if.sv
// Shared payload types and the bus interface for alu_issue_stage.
// reg_val_t carries a 64-bit value plus the six ALU flags; micro_op_t is the op handed to the ALU.
package alu_issue_pkg;

  typedef struct packed {
    logic [63:0] value;
    logic        cf;
    logic        zf;
    logic        sf;
    logic        pf;
    logic        af;
    logic        ovf;
  } reg_val_t;

  typedef struct packed {
    logic [7:0] opcode;
    reg_val_t   src0_val;
    reg_val_t   src1_val;
    reg_val_t   dst_val;
  } micro_op_t;

endpackage

// Upstream push, result broadcast, downstream issue and occupancy, grouped as one bus.
interface alu_issue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
);
  import alu_issue_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  micro_op_t        in_mop;
  logic [TAG_W-1:0] in_src0_tag;
  logic [TAG_W-1:0] in_src1_tag;
  logic             res_valid;
  logic [TAG_W-1:0] res_tag;
  reg_val_t         res_val;
  logic             out_valid;
  logic             out_ready;
  micro_op_t        out_mop;
  logic [CNT_W-1:0] count;

  modport master (
    output flush, in_valid, in_mop, in_src0_tag, in_src1_tag,
    output res_valid, res_tag, res_val, out_ready,
    input  in_ready, out_valid, out_mop, count
  );

  modport slave (
    input  flush, in_valid, in_mop, in_src0_tag, in_src1_tag,
    input  res_valid, res_tag, res_val, out_ready,
    output in_ready, out_valid, out_mop, count
  );

endinterface

// File: rtl/alu_issue_stage.sv
// In-order issue buffer ahead of the ALU: holds up to DEPTH ops, wakes pending sources from the
// result bus and offers the oldest op once both sources are resolved.
// Optional macro ALU_ISSUE_BYPASS_EN: resolve the head combinationally from the current broadcast
// (0-bubble back-to-back dependent ops). Default build has no res_* -> out_* combinational path.
module alu_issue_stage
  import alu_issue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic          clk,
  input  logic          reset,
  alu_issue_if.slave    io
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [TAG_W-1:0] tag0_q  [DEPTH];
  logic [TAG_W-1:0] tag0_d  [DEPTH];
  logic [TAG_W-1:0] tag1_q  [DEPTH];
  logic [TAG_W-1:0] tag1_d  [DEPTH];
  micro_op_t        mop_q   [DEPTH];
  micro_op_t        mop_d   [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             in_ready_c;
  logic             out_valid_c;
  micro_op_t        out_mop_c;
  logic             push_c;
  logic             pop_c;
  logic             res_hit0_c;
  logic             res_hit1_c;
  micro_op_t        new_mop_c;
  logic [TAG_W-1:0] new_tag0_c;
  logic [TAG_W-1:0] new_tag1_c;

  // Head presentation: registered state only, plus same-cycle broadcast merge when bypass is built in.
  always_comb begin
    out_mop_c  = mop_q[head_q];
    res_hit0_c = 1'b0;
    res_hit1_c = 1'b0;
`ifdef ALU_ISSUE_BYPASS_EN
    res_hit0_c = io.res_valid && (tag0_q[head_q] != '0) && (tag0_q[head_q] == io.res_tag);
    res_hit1_c = io.res_valid && (tag1_q[head_q] != '0) && (tag1_q[head_q] == io.res_tag);
    if (res_hit0_c) out_mop_c.src0_val = io.res_val;
    if (res_hit1_c) out_mop_c.src1_val = io.res_val;
`endif
    out_valid_c = valid_q[head_q]
                  && ((tag0_q[head_q] == '0) || res_hit0_c)
                  && ((tag1_q[head_q] == '0) || res_hit1_c);
  end

  // Next-state: wakeup capture, push of the (already captured) incoming op, pop, flush override.
  always_comb begin
    valid_d = valid_q;
    tag0_d  = tag0_q;
    tag1_d  = tag1_q;
    mop_d   = mop_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    in_ready_c = (count_q < CNT_W'(DEPTH));
    push_c     = io.in_valid && in_ready_c;
    pop_c      = out_valid_c && io.out_ready;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && io.res_valid) begin
        if ((tag0_q[i] != '0) && (tag0_q[i] == io.res_tag)) begin
          mop_d[i].src0_val = io.res_val;
          tag0_d[i]         = '0;
        end
        if ((tag1_q[i] != '0) && (tag1_q[i] == io.res_tag)) begin
          mop_d[i].src1_val = io.res_val;
          tag1_d[i]         = '0;
        end
      end
    end

    new_mop_c  = io.in_mop;
    new_tag0_c = io.in_src0_tag;
    new_tag1_c = io.in_src1_tag;
    if (io.res_valid && (new_tag0_c != '0) && (new_tag0_c == io.res_tag)) begin
      new_mop_c.src0_val = io.res_val;
      new_tag0_c         = '0;
    end
    if (io.res_valid && (new_tag1_c != '0) && (new_tag1_c == io.res_tag)) begin
      new_mop_c.src1_val = io.res_val;
      new_tag1_c         = '0;
    end

    if (pop_c) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push_c) begin
      valid_d[tail_q] = 1'b1;
      tag0_d[tail_q]  = new_tag0_c;
      tag1_d[tail_q]  = new_tag1_c;
      mop_d[tail_q]   = new_mop_c;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);

    if (io.flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) valid_d[i] = 1'b0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag0_q[i]  <= '0;
        tag1_q[i]  <= '0;
        mop_q[i]   <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      tag0_q  <= tag0_d;
      tag1_q  <= tag1_d;
      mop_q   <= mop_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_c;
  assign io.out_mop   = out_mop_c;
  assign io.count     = count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (works with or without ALU_ISSUE_BYPASS_EN).
module tb_alu_issue_stage;
  import alu_issue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  alu_issue_if #(.DEPTH(4), .TAG_W(5)) io ();

  alu_issue_stage #(.DEPTH(4), .TAG_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic reg_val_t rv(input logic [63:0] v, input logic [5:0] f);
    reg_val_t r;
    r = reg_val_t'({v, f});
    return r;
  endfunction

  function automatic micro_op_t mk(input logic [7:0] op, input logic [63:0] a,
                                   input logic [63:0] b, input logic [63:0] d);
    micro_op_t m;
    m.opcode   = op;
    m.src0_val = rv(a, 6'b0);
    m.src1_val = rv(b, 6'b0);
    m.dst_val  = rv(d, 6'b000011);
    return m;
  endfunction

  task automatic drive_in(input logic v, input micro_op_t m, input logic [4:0] t0, input logic [4:0] t1);
    io.in_valid    = v;
    io.in_mop      = m;
    io.in_src0_tag = t0;
    io.in_src1_tag = t1;
  endtask

  task automatic drive_res(input logic v, input logic [4:0] t, input reg_val_t r);
    io.res_valid = v;
    io.res_tag   = t;
    io.res_val   = r;
  endtask

  micro_op_t ma, ma2, mb [5], mc, mc_exp, md, md_exp, me, mf, mf_exp, mg, mh;
  reg_val_t  r3, r7, r2;

  initial begin
    reset        = 1'b1;
    io.flush     = 1'b0;
    io.out_ready = 1'b0;
    drive_in(1'b0, '0, 5'd0, 5'd0);
    drive_res(1'b0, 5'd0, '0);
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    check("rst_count", 256'(io.count), 256'(0));
    check("rst_out_valid", 256'(io.out_valid), 256'(0));
    check("rst_in_ready", 256'(io.in_ready), 256'(1));
    check("rst_out_mop", 256'(io.out_mop), 256'(0));

    // 1: single resolved op, 1-cycle latency, then push+pop in the same cycle
    ma  = mk(8'h01, 64'h1111, 64'h2222, 64'hdead);
    ma2 = mk(8'h02, 64'h3333, 64'h4444, 64'hbeef);
    io.out_ready = 1'b1;
    drive_in(1'b1, ma, 5'd0, 5'd0);
    tick();
    check("t1_count1", 256'(io.count), 256'(1));
    check("t1_valid", 256'(io.out_valid), 256'(1));
    check("t1_mop", 256'(io.out_mop), 256'(ma));
    drive_in(1'b1, ma2, 5'd0, 5'd0);
    tick();
    check("t1_pushpop_count", 256'(io.count), 256'(1));
    check("t1_pushpop_mop", 256'(io.out_mop), 256'(ma2));
    drive_in(1'b0, '0, 5'd0, 5'd0);
    tick();
    check("t1_count0", 256'(io.count), 256'(0));
    check("t1_empty_valid", 256'(io.out_valid), 256'(0));

    // 2: fill to 4, fifth push ignored, drain in order (pointers wrap)
    io.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) mb[i] = mk(8'h10 + 8'(i), 64'(i), 64'(i * 3), 64'(i + 100));
    for (int i = 0; i < 4; i++) begin
      drive_in(1'b1, mb[i], 5'd0, 5'd0);
      tick();
    end
    check("t2_count4", 256'(io.count), 256'(4));
    check("t2_in_ready0", 256'(io.in_ready), 256'(0));
    drive_in(1'b1, mb[4], 5'd0, 5'd0);
    tick();
    check("t2_count_still4", 256'(io.count), 256'(4));
    check("t2_stall_mop", 256'(io.out_mop), 256'(mb[0]));
    drive_in(1'b0, '0, 5'd0, 5'd0);
    io.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t2_drain_valid%0d", i), 256'(io.out_valid), 256'(1));
      check($sformatf("t2_drain_mop%0d", i), 256'(io.out_mop), 256'(mb[i]));
      tick();
    end
    check("t2_count0", 256'(io.count), 256'(0));

    // 3: head src1 pending on tag 3, wakeup with full flags
    io.out_ready = 1'b0;
    mc = mk(8'h20, 64'haaaa, 64'h0, 64'h5);
    r3 = rv(64'h10, 6'b100000);
    mc_exp = mc;
    mc_exp.src1_val = r3;
    drive_in(1'b1, mc, 5'd0, 5'd3);
    tick();
    drive_in(1'b0, '0, 5'd0, 5'd0);
    check("t3_pending_valid", 256'(io.out_valid), 256'(0));
    drive_res(1'b1, 5'd3, r3);
    #1;
`ifdef ALU_ISSUE_BYPASS_EN
    check("t3_bypass_valid", 256'(io.out_valid), 256'(1));
    check("t3_bypass_mop", 256'(io.out_mop), 256'(mc_exp));
`else
    check("t3_nobypass_valid", 256'(io.out_valid), 256'(0));
`endif
    tick();
    drive_res(1'b0, 5'd0, '0);
    #1;
    check("t3_valid", 256'(io.out_valid), 256'(1));
    check("t3_mop", 256'(io.out_mop), 256'(mc_exp));
    io.out_ready = 1'b1;
    tick();
    check("t3_count0", 256'(io.count), 256'(0));

    // 4: unresolved head blocks a resolved younger op
    md = mk(8'h30, 64'h0, 64'h77, 64'h1);
    me = mk(8'h31, 64'h88, 64'h99, 64'h2);
    r7 = rv(64'h1234_5678, 6'b011111);
    md_exp = md;
    md_exp.src0_val = r7;
    drive_in(1'b1, md, 5'd7, 5'd0);
    tick();
    drive_in(1'b1, me, 5'd0, 5'd0);
    tick();
    drive_in(1'b0, '0, 5'd0, 5'd0);
    tick();
    tick();
    check("t4_blocked_valid", 256'(io.out_valid), 256'(0));
    check("t4_blocked_count", 256'(io.count), 256'(2));
    drive_res(1'b1, 5'd7, r7);
`ifdef ALU_ISSUE_BYPASS_EN
    #1;
    check("t4_head_valid", 256'(io.out_valid), 256'(1));
    check("t4_head_mop", 256'(io.out_mop), 256'(md_exp));
    tick();
    drive_res(1'b0, 5'd0, '0);
    #1;
`else
    tick();
    drive_res(1'b0, 5'd0, '0);
    #1;
    check("t4_head_valid", 256'(io.out_valid), 256'(1));
    check("t4_head_mop", 256'(io.out_mop), 256'(md_exp));
    tick();
`endif
    check("t4_second_mop", 256'(io.out_mop), 256'(me));
    check("t4_count1", 256'(io.count), 256'(1));
    tick();
    check("t4_count0", 256'(io.count), 256'(0));

    // 5: broadcast in the same cycle as the push of its consumer
    io.out_ready = 1'b0;
    mf = mk(8'h40, 64'h0, 64'h55, 64'h3);
    r2 = rv(64'hffff_0000_ffff_0000, 6'b010101);
    mf_exp = mf;
    mf_exp.src0_val = r2;
    drive_in(1'b1, mf, 5'd2, 5'd0);
    drive_res(1'b1, 5'd2, r2);
    tick();
    drive_res(1'b0, 5'd0, '0);
    drive_in(1'b0, '0, 5'd0, 5'd0);
    #1;
    check("t5_valid", 256'(io.out_valid), 256'(1));
    check("t5_mop", 256'(io.out_mop), 256'(mf_exp));

    // 6: flush with count 3 and a same-cycle push, then reset mid-stall
    mg = mk(8'h50, 64'h1, 64'h2, 64'h3);
    mh = mk(8'h51, 64'h4, 64'h5, 64'h6);
    drive_in(1'b1, mg, 5'd0, 5'd9);
    tick();
    drive_in(1'b1, mh, 5'd0, 5'd0);
    tick();
    check("t6_count3", 256'(io.count), 256'(3));
    drive_in(1'b1, ma, 5'd0, 5'd0);
    io.flush = 1'b1;
    tick();
    io.flush = 1'b0;
    drive_in(1'b0, '0, 5'd0, 5'd0);
    #1;
    check("t6_flush_count", 256'(io.count), 256'(0));
    check("t6_flush_valid", 256'(io.out_valid), 256'(0));
    check("t6_flush_in_ready", 256'(io.in_ready), 256'(1));
    drive_in(1'b1, mg, 5'd0, 5'd0);
    tick();
    drive_in(1'b1, mh, 5'd0, 5'd0);
    tick();
    check("t6_refill_count", 256'(io.count), 256'(2));
    check("t6_refill_mop", 256'(io.out_mop), 256'(mg));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive_in(1'b0, '0, 5'd0, 5'd0);
    #1;
    check("t6_reset_count", 256'(io.count), 256'(0));
    check("t6_reset_valid", 256'(io.out_valid), 256'(0));
    check("t6_reset_mop", 256'(io.out_mop), 256'(0));
    drive_in(1'b1, mh, 5'd0, 5'd0);
    tick();
    drive_in(1'b0, '0, 5'd0, 5'd0);
    check("t6_post_reset_mop", 256'(io.out_mop), 256'(mh));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
